// File: rtl/uart_pkg.sv
// Shared UART types and line constants for the rx/tx pair.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } t_parity;

  localparam logic IDLE_VAL  = 1'b1;
  localparam logic START_VAL = 1'b0;
  localparam logic STOP_VAL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5,
    BREAK  = 3'd6
  } t_rx_state;

  // Map the raw 2-bit parity select onto t_parity; code 3 means no parity.
  function automatic t_parity to_parity(input logic [1:0] mode);
    case (mode)
      2'd1:    return PARITY_EVEN;
      2'd2:    return PARITY_ODD;
      default: return PARITY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: serial line and frame config in, decoded byte and status out.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);

  logic                 rx;
  logic [1:0]           stop_bits;
  logic [1:0]           parity_mode;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 rx_busy;

  modport master (
    output rx, stop_bits, parity_mode,
    input  rx_data, rx_valid, parity_err, frame_err, rx_busy
  );

  modport slave (
    input  rx, stop_bits, parity_mode,
    output rx_data, rx_valid, parity_err, frame_err, rx_busy
  );

endinterface

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for a single asynchronous input.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both reset to the line's idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8
) (
  input logic     clk,
  input logic     rst,
  uart_rx_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_TICK = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  t_rx_state            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 two_stop_q, two_stop_d;
  t_parity              par_q, par_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 fin_c;

  uart_sync2 #(.RST_VAL(IDLE_VAL)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      two_stop_q <= 1'b0;
      par_q      <= PARITY_NONE;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      two_stop_q <= two_stop_d;
      par_q      <= par_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  // Next-state logic: every sample after the start check lands one bit period later.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == CNT_TICK) ? '0 : cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    shift_d    = shift_q;
    two_stop_d = two_stop_q;
    par_d      = par_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    fin_c      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_s == START_VAL) begin
          state_d    = START;
          two_stop_d = (bus.stop_bits == 2'd2);
          par_d      = to_parity(bus.parity_mode);
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          idx_d      = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = (rx_s == START_VAL) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (cnt_q == CNT_TICK) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = (par_q == PARITY_NONE) ? STOP : PARITY;
          end
        end
      end
      PARITY: begin
        if (cnt_q == CNT_TICK) begin
          perr_d  = (par_q == PARITY_EVEN) ? (rx_s != ^shift_q) : (rx_s != ~^shift_q);
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_TICK) begin
          ferr_d = (rx_s != STOP_VAL);
          if (two_stop_q) begin
            state_d = STOP2;
          end else begin
            fin_c = 1'b1;
          end
        end
      end
      STOP2: begin
        if (cnt_q == CNT_TICK) begin
          ferr_d = ferr_q | (rx_s != STOP_VAL);
          fin_c  = 1'b1;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s == IDLE_VAL) begin
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Finishing at mid-stop: a line still low here is a break, not a new start.
    if (fin_c) begin
      cnt_d   = '0;
      state_d = (rx_s == IDLE_VAL) ? IDLE : BREAK;
    end
  end

  // Registered outputs: byte and flags load together with the valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rx_data    <= '0;
      bus.rx_valid   <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.rx_busy    <= 1'b0;
    end else begin
      bus.rx_valid <= fin_c;
      bus.rx_busy  <= (state_d != IDLE);
      if (fin_c) begin
        bus.rx_data    <= shift_q;
        bus.parity_err <= perr_q;
        bus.frame_err  <= ferr_d;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's uart_tx.
- Converts an asynchronous serial line into parallel bytes with per-byte parity and framing status.
- Sits between the external rx pin and the interface's receive FIFO/host logic.
- Supports 8 data bits LSB-first, none/even/odd parity and 1 or 2 stop bits, sampling each bit at mid-bit using a clock-cycle bit counter.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); must be >= 4.
- DATA_BITS, 8, data bits per frame; rx_data width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- rx  in  1  asynchronous serial input; idle high.
- stop_bits  in  2  stop bits expected: 2 = two, any other value = one.
- parity_mode  in  2  parity: 0 = none, 1 = even, 2 = odd, 3 = none.
- rx_data  out  DATA_BITS  last received byte; holds until the next rx_valid.
- rx_valid  out  1  one-cycle pulse when rx_data and the error flags update.
- parity_err  out  1  received parity bit mismatched; valid with rx_valid, held until the next rx_valid.
- frame_err  out  1  a stop bit was sampled 0; valid with rx_valid, held until the next rx_valid.
- rx_busy  out  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, rx_busy=0, synchronizer flops=1, state=IDLE, counters=0.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, giving a fixed 2-cycle input latency.
- States: IDLE, START, DATA, PARITY, STOP, STOP2, BREAK.
- Bit counter cnt counts 0..CLKS_PER_BIT-1. "Mid" means cnt == CLKS_PER_BIT/2 - 1 in START; "tick" means cnt == CLKS_PER_BIT-1 in all other states.
- IDLE -> START on the cycle rx_s is first seen 0. That same cycle latches stop_bits and parity_mode; mid-frame input changes are ignored.
- START at mid:
  - rx_s == 1: false start, return to IDLE with no output.
  - rx_s == 0: go to DATA, clear cnt, bit index = 0.
- Every later sample lands one full bit period after the previous one, i.e. at the bit centre.
- DATA at tick: shift rx_s into the shift register LSB-first and increment the bit index. After bit DATA_BITS-1, go to PARITY if latched parity is even/odd, else STOP.
- PARITY at tick: capture the parity bit.
  - Even: error if bit != ^data.
  - Odd: error if bit != ~^data.
- STOP at tick: frame_err_int = (rx_s == 0).
  - Two stop bits latched: go to STOP2.
  - One stop bit: finish.
- STOP2 at tick: frame_err_int |= (rx_s == 0), then finish.
- Finish, next cycle:
  - rx_valid=1 for exactly one cycle.
  - rx_data, parity_err and frame_err load together.
  - State -> IDLE if rx_s == 1, else BREAK.
  - Finishing at mid-stop lets a following start edge be caught with up to half a bit of margin.
- BREAK: wait for rx_s == 1, then go to IDLE. There is no rx_valid in BREAK, so a held-low line yields exactly one frame with frame_err=1 and data 0.
- A frame with a framing error is still delivered (rx_valid=1, frame_err=1). Consumers decide whether to drop it.
- Back-to-back frames: no idle cycles are required between the last stop bit and the next start bit.
- rst asserted mid-frame: the next cycle is IDLE with all outputs at reset values. The partial frame is discarded with no rx_valid.

Decomposition:
- uart_pkg holds:
  - parity enum t_parity (PARITY_NONE, PARITY_EVEN, PARITY_ODD).
  - Line constants IDLE_VAL=1, START_VAL=0, STOP_VAL=1.
  - State enum t_rx_state, 3 bits wide to fit 7 states.
  - uart_tx is to adopt t_parity in place of its string parity port.
- Sub-module uart_sync2: generic 2-flop synchronizer with a reset value parameter (1 here). It is reusable for other async inputs.

Test Plan (CLKS_PER_BIT=16):
1. No parity, 1 stop, send 0xA5 -> one rx_valid pulse with rx_data=0xA5, parity_err=0, frame_err=0. rx_valid occurs 2 + 16·9 + 8 (±1) cycles after the start edge on rx.
2. Even parity, send 0x07 with parity bit 1 -> rx_data=0x07, parity_err=0. Repeat with parity bit 0 -> parity_err=1. Odd parity with 0x07 and bit 0 -> parity_err=0.
3. 2 stop bits, send 0x3C with second stop bit driven 0 -> rx_data=0x3C, frame_err=1. Then hold rx low 40 bit times -> no extra rx_valid, and the next frame after rx returns high decodes cleanly.
4. Glitch: rx low for 5 cycles, then high -> no rx_valid, rx_busy falls by cycle 10, state=IDLE.
5. Back-to-back 0x55, 0xAA, 0xFF with no idle gap and ±3% baud skew on the driver -> three rx_valid pulses with correct data and no errors.
6. Assert rst for 1 cycle during DATA bit 4 -> no rx_valid, all outputs at 0; the following frame 0x81 decodes correctly.
